// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control FSM and its datapath:
// state codes, opcode constants, mux-select encodings and the control bundle.
package multicycle_ctrl_fsm_pkg;

  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_FAULT    = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic ADR_PC  = 1'b0;
  localparam logic ADR_ALU = 1'b1;

  // Registered (Moore) part of the control word.
  typedef struct packed {
    logic       pc_write;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       reg_write;
    logic       fault;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory request/ready handshake between the control FSM and the memory.
interface multicycle_ctrl_fsm_if;
  logic mem_req_o;
  logic mem_we_o;
  logic adr_src_o;
  logic mem_ready_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output adr_src_o,
    input  mem_ready_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  adr_src_o,
    output mem_ready_i
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Counts cycles spent waiting on memory ready and flags the cycle in which
// the MEM_TIMEOUT-th consecutive wait happens.
module multicycle_ctrl_fsm_mem_wait_timer
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic wait_i,
  output logic timeout_o
);

  localparam logic [WAIT_CNT_W-1:0] TERM_CNT = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on state entry, step on every unanswered request cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wait_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds waits already elapsed, so this cycle is wait number cnt_q+1.
  assign timeout_o = wait_i && (cnt_q == TERM_CNT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RISC-V style control FSM.
//
// state     | meaning
// ----------+-------------------------------------------------
// FETCH     | read instruction at PC, PC+4 precompute
// DECODE    | branch target precompute, dispatch on opcode
// MEMADR    | load/store address rs1+imm
// MEMREAD   | load data request
// MEMWB     | write load data to rd
// MEMWRITE  | store data request
// EXECR     | ALU rs1 op rs2
// EXECI     | ALU rs1 op imm
// ALUWB     | write ALUOut to rd
// BRANCH    | compare rs1-rs2, take on zero
// JAL/JALR  | link value oldPC+4, redirect PC
// FAULT     | illegal opcode/state or memory timeout, sticky
//
// The Moore control word is registered alongside the state (decoded from the
// next state). pc_write/ir_write also have terms driven by mem_ready_i and
// zero_i. All outputs are forced low while rst_n_i is low.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [6:0]            opcode_i,
  input  logic                  zero_i,
  multicycle_ctrl_fsm_if.master mem,
  output logic                  pc_write_o,
  output logic                  ir_write_o,
  output logic                  reg_write_o,
  output logic                  fault_o,
  output logic [1:0]            alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [1:0]            alu_op_o,
  output logic [1:0]            result_src_o,
  output logic [1:0]            imm_src_o,
  output logic [3:0]            state_o
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d, ctrl_out;
  logic   mem_done, mem_wait, timeout, timer_clr;

  function automatic ctrl_t ctrl_decode(input state_t st, input logic [6:0] opc);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_req    = 1'b1;
        c.adr_src    = ADR_PC;
        c.alu_src_a  = SRC_A_PC;
        c.alu_src_b  = SRC_B_FOUR;
        c.alu_op     = ALU_ADD;
        c.result_src = RES_ALURES;
      end
      ST_DECODE: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
        c.imm_src   = IMM_B;
      end
      ST_MEMADR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.imm_src   = (opc == OP_LOAD) ? IMM_I : IMM_S;
      end
      ST_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = ADR_ALU;
      end
      ST_MEMWB: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_MEMDATA;
      end
      ST_MEMWRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.adr_src = ADR_ALU;
      end
      ST_EXECR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_FUNCT;
      end
      ST_EXECI: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_FUNCT;
        c.imm_src   = IMM_I;
      end
      ST_ALUWB: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      ST_BRANCH: begin
        c.alu_src_a  = SRC_A_RS1;
        c.alu_src_b  = SRC_B_RS2;
        c.alu_op     = ALU_SUB;
        c.result_src = RES_ALUOUT;
      end
      ST_JAL: begin
        c.alu_src_a  = SRC_A_OLDPC;
        c.alu_src_b  = SRC_B_FOUR;
        c.imm_src    = IMM_J;
        c.pc_write   = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      // Link value oldPC+4 on the ALU; the jump target rs1+imm uses the I immediate.
      ST_JALR: begin
        c.alu_src_a  = SRC_A_OLDPC;
        c.alu_src_b  = SRC_B_FOUR;
        c.imm_src    = IMM_I;
        c.pc_write   = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      default: begin
        c.fault = 1'b1;
      end
    endcase
    return c;
  endfunction

  // Reset gates every output so nothing leaks while rst_n_i is low.
  assign ctrl_out = rst_n_i ? ctrl_q : '0;

  // mem_ready_i only counts while a request is actually being driven.
  assign mem_done  = ctrl_out.mem_req & mem.mem_ready_i;
  assign mem_wait  = ctrl_out.mem_req & ~mem.mem_ready_i;
  assign timer_clr = (state_d != state_q);

  multicycle_ctrl_fsm_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (timer_clr),
    .wait_i   (mem_wait),
    .timeout_o(timeout)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (timeout) begin
          state_d = ST_FAULT;
        end else if (mem_done) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: state_d = ST_MEMADR;
          OP_RTYPE:          state_d = ST_EXECR;
          OP_ITYPE:          state_d = ST_EXECI;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_JAL:            state_d = ST_JAL;
          OP_JALR:           state_d = ST_JALR;
          default:           state_d = ST_FAULT;
        endcase
      end
      ST_MEMADR: begin
        if (opcode_i == OP_LOAD) begin
          state_d = ST_MEMREAD;
        end else if (opcode_i == OP_STORE) begin
          state_d = ST_MEMWRITE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_MEMREAD: begin
        if (timeout) begin
          state_d = ST_FAULT;
        end else if (mem_done) begin
          state_d = ST_MEMWB;
        end
      end
      ST_MEMWRITE: begin
        if (timeout) begin
          state_d = ST_FAULT;
        end else if (mem_done) begin
          state_d = ST_FETCH;
        end
      end
      ST_MEMWB, ST_ALUWB, ST_BRANCH: state_d = ST_FETCH;
      ST_EXECR, ST_EXECI, ST_JAL, ST_JALR: state_d = ST_ALUWB;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // Control word for the state being entered.
  always_comb begin
    ctrl_d = ctrl_decode(state_d, opcode_i);
  end

  // State and registered control word; reset lands in a ready-to-run FETCH.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_FETCH;
      ctrl_q  <= ctrl_decode(ST_FETCH, OP_LOAD);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign pc_write_o = ctrl_out.pc_write
                    | ((state_q == ST_FETCH) & mem_done)
                    | (rst_n_i & (state_q == ST_BRANCH) & zero_i);
  assign ir_write_o = (state_q == ST_FETCH) & mem_done;

  assign mem.mem_req_o = ctrl_out.mem_req;
  assign mem.mem_we_o  = ctrl_out.mem_we;
  assign mem.adr_src_o = ctrl_out.adr_src;

  assign reg_write_o  = ctrl_out.reg_write;
  assign fault_o      = ctrl_out.fault;
  assign alu_src_a_o  = ctrl_out.alu_src_a;
  assign alu_src_b_o  = ctrl_out.alu_src_b;
  assign alu_op_o     = ctrl_out.alu_op;
  assign result_src_o = ctrl_out.result_src;
  assign imm_src_o    = ctrl_out.imm_src;
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction expected state traces with
// random memory latencies, checked every cycle against a per-state output table.
module tb_multicycle_ctrl_fsm;
  import multicycle_ctrl_fsm_pkg::*;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       pc_write, ir_write, reg_write, fault;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  state_t tr_st[$];
  bit     tr_rdy[$];

  multicycle_ctrl_fsm_if mif ();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .opcode_i    (opcode),
    .zero_i      (zero),
    .mem         (mif.master),
    .pc_write_o  (pc_write),
    .ir_write_o  (ir_write),
    .reg_write_o (reg_write),
    .fault_o     (fault),
    .alu_src_a_o (alu_src_a),
    .alu_src_b_o (alu_src_b),
    .alu_op_o    (alu_op),
    .result_src_o(result_src),
    .imm_src_o   (imm_src),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // bits: [20:17] state, 16 pc_write, 15 ir_write, 14 req, 13 we, 12 adr,
  // 11 reg_write, 10 fault, 9:8 a, 7:6 b, 5:4 op, 3:2 res, 1:0 imm
  function automatic logic [20:0] obs();
    return {state, pc_write, ir_write, mif.mem_req_o, mif.mem_we_o, mif.adr_src_o,
            reg_write, fault, alu_src_a, alu_src_b, alu_op, result_src, imm_src};
  endfunction

  // Expected outputs straight from the per-state control table.
  function automatic logic [20:0] exp_vec(state_t st, bit rdy, bit z, logic [6:0] opc);
    logic [3:0] s;
    logic pw, iw, rq, we, ad, rw, f;
    logic [1:0] a, b, op, res, imm;
    s = st;
    {pw, iw, rq, we, ad, rw, f} = '0;
    {a, b, op, res, imm} = '0;
    case (st)
      ST_FETCH:    begin rq = 1; b = 2'b10; res = 2'b10; pw = rdy; iw = rdy; end
      ST_DECODE:   begin a = 2'b01; b = 2'b01; imm = 2'b10; end
      ST_MEMADR:   begin a = 2'b10; b = 2'b01; imm = (opc == 7'b0000011) ? 2'b00 : 2'b01; end
      ST_MEMREAD:  begin rq = 1; ad = 1; end
      ST_MEMWB:    begin rw = 1; res = 2'b01; end
      ST_MEMWRITE: begin rq = 1; we = 1; ad = 1; end
      ST_EXECR:    begin a = 2'b10; op = 2'b10; end
      ST_EXECI:    begin a = 2'b10; b = 2'b01; op = 2'b10; end
      ST_ALUWB:    begin rw = 1; end
      ST_BRANCH:   begin a = 2'b10; op = 2'b01; pw = z; end
      ST_JAL:      begin a = 2'b01; b = 2'b10; imm = 2'b11; pw = 1; end
      ST_JALR:     begin a = 2'b01; b = 2'b10; pw = 1; end
      default:     begin f = 1; end
    endcase
    return {s, pw, iw, rq, we, ad, rw, f, a, b, op, res, imm};
  endfunction

  // One clock: drive inputs just after the edge, return at the sample point.
  task automatic cycle(input bit rdy, input bit z, input bit rst);
    @(posedge clk);
    #1;
    rst_n = rst;
    mif.mem_ready_i = rdy;
    zero = z;
    #3;
  endtask

  task automatic push(input state_t s, input bit r);
    tr_st.push_back(s);
    tr_rdy.push_back(r);
  endtask

  // Ready is irrelevant outside request states, so it is randomised there.
  task automatic push_idle(input state_t s);
    push(s, 1'($urandom_range(0, 1)));
  endtask

  task automatic push_wait(input state_t s, input int dly);
    for (int k = 0; k < dly; k++) push(s, 1'b0);
    push(s, 1'b1);
  endtask

  // Expected state sequence for one instruction from its class and latencies.
  task automatic build(input logic [6:0] opc, input int fd, input int md);
    tr_st.delete();
    tr_rdy.delete();
    push_wait(ST_FETCH, fd);
    push_idle(ST_DECODE);
    case (opc)
      7'b0000011: begin push_idle(ST_MEMADR); push_wait(ST_MEMREAD, md); push_idle(ST_MEMWB); end
      7'b0100011: begin push_idle(ST_MEMADR); push_wait(ST_MEMWRITE, md); end
      7'b0110011: begin push_idle(ST_EXECR); push_idle(ST_ALUWB); end
      7'b0010011: begin push_idle(ST_EXECI); push_idle(ST_ALUWB); end
      7'b1100011: push_idle(ST_BRANCH);
      7'b1101111: begin push_idle(ST_JAL); push_idle(ST_ALUWB); end
      7'b1100111: begin push_idle(ST_JALR); push_idle(ST_ALUWB); end
      default:    for (int k = 0; k < 10; k++) push_idle(ST_FAULT);
    endcase
  endtask

  task automatic test_reset();
    logic [20:0] o, e;
    e = {4'(ST_FETCH), 17'b0};
    for (int i = 0; i < 3; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_add();
    logic [20:0] o, e;
    int rw_cnt, rw_at;
    opcode = 7'b0110011;
    build(opcode, 0, 0);
    push(ST_FETCH, 1'b0);
    rw_cnt = 0;
    rw_at = -1;
    for (int i = 0; i < tr_st.size(); i++) begin
      cycle(tr_rdy[i], 1'b0, 1'b1);
      o = obs();
      e = exp_vec(tr_st[i], tr_rdy[i], 1'b0, opcode);
      if (o[11]) begin rw_cnt++; rw_at = i; end
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL add_trace cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    checks++;
    if (rw_cnt !== 1 || rw_at !== 3) begin
      failures++;
      $display("FAIL add_reg_write_pulse count=%0d at=%0d exp count=1 at=3", rw_cnt, rw_at);
    end
  endtask

  task automatic test_lw_delay();
    logic [20:0] o, e;
    int req_cnt;
    opcode = 7'b0000011;
    build(opcode, 0, 3);
    req_cnt = 0;
    for (int i = 0; i < tr_st.size(); i++) begin
      cycle(tr_rdy[i], 1'b0, 1'b1);
      o = obs();
      e = exp_vec(tr_st[i], tr_rdy[i], 1'b0, opcode);
      if (o[14] && o[12]) req_cnt++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL lw_trace cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    checks++;
    if (req_cnt !== 4) begin
      failures++;
      $display("FAIL lw_req_hold got=%0d exp=4", req_cnt);
    end
  endtask

  task automatic test_branch();
    logic [20:0] o, e;
    bit z;
    opcode = 7'b1100011;
    for (int t = 0; t < 2; t++) begin
      z = (t == 0);
      build(opcode, t, 0);
      for (int i = 0; i < tr_st.size(); i++) begin
        cycle(tr_rdy[i], z, 1'b1);
        o = obs();
        e = exp_vec(tr_st[i], tr_rdy[i], z, opcode);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL branch_trace z=%0d cyc=%0d got=%h exp=%h", z, i, o, e);
        end
        if (tr_st[i] == ST_BRANCH) begin
          checks++;
          if (o[16] !== z) begin
            failures++;
            $display("FAIL branch_pc_write z=%0d got=%b exp=%b", z, o[16], z);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [20:0] o, e;
    logic [6:0] ops [7];
    bit z;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111};
    for (int n = 0; n < 40; n++) begin
      opcode = ops[$urandom_range(0, 6)];
      z = 1'($urandom_range(0, 1));
      build(opcode, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
      for (int i = 0; i < tr_st.size(); i++) begin
        cycle(tr_rdy[i], z, 1'b1);
        o = obs();
        e = exp_vec(tr_st[i], tr_rdy[i], z, opcode);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL random_trace n=%0d op=%b cyc=%0d got=%h exp=%h", n, opcode, i, o, e);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [20:0] o, e;
    opcode = 7'b0110011;
    tr_st.delete();
    tr_rdy.delete();
    for (int k = 0; k < TMO; k++) push(ST_FETCH, 1'b0);
    for (int k = 0; k < 4; k++) push_idle(ST_FAULT);
    for (int i = 0; i < tr_st.size(); i++) begin
      cycle(tr_rdy[i], 1'b0, 1'b1);
      o = obs();
      e = exp_vec(tr_st[i], tr_rdy[i], 1'b0, opcode);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL timeout_trace cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midwrite();
    logic [20:0] o, e;
    opcode = 7'b0100011;
    build(opcode, 0, 3);
    for (int i = 0; i < 4; i++) begin
      cycle(tr_rdy[i], 1'b0, 1'b1);
      o = obs();
      e = exp_vec(tr_st[i], tr_rdy[i], 1'b0, opcode);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midwrite_pre cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
    o = obs();
    checks++;
    if (o[16] !== 1'b0 || o[11] !== 1'b0 || o[13] !== 1'b0) begin
      failures++;
      $display("FAIL midwrite_in_reset pw/rw/we got=%b%b%b exp=000", o[16], o[11], o[13]);
    end
    cycle(1'b0, 1'b0, 1'b1);
    o = obs();
    e = exp_vec(ST_FETCH, 1'b0, 1'b0, opcode);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL midwrite_fresh_fetch got=%h exp=%h", o, e);
    end
    opcode = 7'b0110011;
    build(opcode, 0, 0);
    for (int i = 0; i < tr_st.size(); i++) begin
      cycle(tr_rdy[i], 1'b0, 1'b1);
      o = obs();
      e = exp_vec(tr_st[i], tr_rdy[i], 1'b0, opcode);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midwrite_after cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_illegal();
    logic [20:0] o, e;
    opcode = 7'b0000000;
    build(opcode, 1, 0);
    for (int i = 0; i < tr_st.size(); i++) begin
      cycle(tr_rdy[i], 1'b0, 1'b1);
      o = obs();
      e = exp_vec(tr_st[i], tr_rdy[i], 1'b0, opcode);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL illegal_trace cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    o = obs();
    e = {4'(ST_FETCH), 17'b0};
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL illegal_reset got=%h exp=%h", o, e);
    end
    cycle(1'b0, 1'b0, 1'b1);
    o = obs();
    e = exp_vec(ST_FETCH, 1'b0, 1'b0, opcode);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL illegal_release got=%h exp=%h", o, e);
    end
  endtask

  initial begin
    mif.mem_ready_i = 1'b0;
    test_reset();
    test_add();
    test_lw_delay();
    test_branch();
    test_random();
    test_timeout();
    test_reset_midwrite();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
